// File: rtl/bram_pkg.sv
// Shared definitions for the simple-dual-port block RAM controller.
//   clr_state_e : zero-fill sequencer states (CLEAR while filling, READY otherwise)
//   calc_nb()   : number of byte lanes for a given word width
//   width_ok()  : legality test for the word width, used at elaboration
package bram_pkg;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_READY = 1'b1
   } clr_state_e;

   localparam int BYTE_W = 8;

   function automatic int calc_nb(input int data_width);
      return data_width / BYTE_W;
   endfunction

   function automatic bit width_ok(input int data_width);
      return (data_width > 0) && ((data_width % BYTE_W) == 0);
   endfunction

endpackage

// File: rtl/bram_sdp_array.sv
// Reset-free storage array: one write port with byte enables, one read port
// with a registered output. Read-first on a same-address write, so any
// write-first behaviour is layered on top by the controller.
// Ports:
//   clka  : clock
//   waddr : write word address      wdata : write word
//   we    : per-byte write enables  (lane i covers wdata[8i+7:8i])
//   raddr : read word address       re    : read enable (rdata holds when 0)
//   rdata : registered read word
module bram_sdp_array
   import bram_pkg::*;
#(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 32,
   parameter int NB         = calc_nb(DATA_WIDTH),
   parameter     INIT_FILE  = ""
) (
   input  logic                  clka,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [NB-1:0]         we,
   input  logic [ADDR_WIDTH-1:0] raddr,
   input  logic                  re,
   output logic [DATA_WIDTH-1:0] rdata
);

   localparam int DEPTH = 2**ADDR_WIDTH;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clka) begin
      for (int i = 0; i < NB; i++) begin
         if (we[i]) begin
            mem[waddr][i*BYTE_W +: BYTE_W] <= wdata[i*BYTE_W +: BYTE_W];
         end
      end
      if (re) begin
         rdata <= mem[raddr];
      end
   end

endmodule

// File: rtl/bram_sdp_ctrl.sv
// Simple-dual-port block RAM controller: port A writes with byte enables,
// port B reads with a valid flag, optional output register, optional
// same-address write-first bypass and an optional post-reset zero fill.
// Ports:
//   clka, rsta    : clock, synchronous active-high reset
//   addra/dina/wea: write address, data, byte enables
//   addrb/reb     : read address, read request
//   doutb         : read data (holds between results, 0 after reset)
//   doutb_valid   : doutb carries the result of a request 1+OUT_REG edges old
//   init_busy     : zero fill running; both ports are ignored
module bram_sdp_ctrl
   import bram_pkg::*;
#(
   parameter int ADDR_WIDTH     = 12,
   parameter int DATA_WIDTH     = 32,
   parameter int OUT_REG        = 0,
   parameter int BYPASS         = 1,
   parameter int CLEAR_ON_RESET = 0,
   parameter     INIT_FILE      = ""
) (
   input  logic                          clka,
   input  logic                          rsta,
   input  logic [ADDR_WIDTH-1:0]         addra,
   input  logic [DATA_WIDTH-1:0]         dina,
   input  logic [calc_nb(DATA_WIDTH)-1:0] wea,
   input  logic [ADDR_WIDTH-1:0]         addrb,
   input  logic                          reb,
   output logic [DATA_WIDTH-1:0]         doutb,
   output logic                          doutb_valid,
   output logic                          init_busy
);

   localparam int NB = calc_nb(DATA_WIDTH);

   generate
      if (!width_ok(DATA_WIDTH)) begin : g_bad_width
         $error("bram_sdp_ctrl: DATA_WIDTH must be a non-zero multiple of 8");
      end
   endgenerate

   clr_state_e            state_reg, state_next;
   logic [ADDR_WIDTH-1:0] clr_cnt_reg;
   logic [ADDR_WIDTH-1:0] mem_waddr;
   logic [DATA_WIDTH-1:0] mem_wdata;
   logic [NB-1:0]         mem_we;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] mem_rdata;
   logic [DATA_WIDTH-1:0] rd_merged;
   logic [NB-1:0]         byp_mask_reg;
   logic [DATA_WIDTH-1:0] byp_data_reg;
   logic                  rd_v1_reg;

   // Zero-fill sequencer: state register and fill counter.
   always_ff @(posedge clka) begin
      if (rsta) begin
         state_reg   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
         clr_cnt_reg <= '0;
      end else begin
         state_reg <= state_next;
         if (state_reg == ST_CLEAR) begin
            clr_cnt_reg <= clr_cnt_reg + ADDR_WIDTH'(1);
         end
      end
   end

   always_comb begin
      state_next = state_reg;
      if (state_reg == ST_CLEAR && clr_cnt_reg == '1) begin
         state_next = ST_READY;
      end
   end

   // Outputs of the sequencer: write-port mux and read gating. Nothing
   // reaches the array while rsta is high so a reset never corrupts data.
   always_comb begin
      init_busy = (state_reg == ST_CLEAR);
      mem_we    = '0;
      mem_waddr = addra;
      mem_wdata = dina;
      rd_en     = 1'b0;
      if (!rsta) begin
         if (state_reg == ST_CLEAR) begin
            mem_we    = '1;
            mem_waddr = clr_cnt_reg;
            mem_wdata = '0;
         end else begin
            mem_we = wea;
            rd_en  = reb;
         end
      end
   end

   bram_sdp_array #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .NB         (NB),
      .INIT_FILE  (INIT_FILE)
   ) u_array (
      .clka  (clka),
      .waddr (mem_waddr),
      .wdata (mem_wdata),
      .we    (mem_we),
      .raddr (addrb),
      .re    (rd_en),
      .rdata (mem_rdata)
   );

   // The array returns the old word on a collision; remember which lanes
   // were written in that same cycle so they can be replaced afterwards.
   // Captured only with a read so the merge stays consistent with the held
   // array output.
   always_ff @(posedge clka) begin
      if (rsta) begin
         byp_mask_reg <= '0;
         rd_v1_reg    <= 1'b0;
      end else begin
         rd_v1_reg <= rd_en;
         if (rd_en) begin
            byp_mask_reg <= (BYPASS != 0 && addra == addrb) ? wea : '0;
            byp_data_reg <= dina;
         end
      end
   end

   generate
      for (genvar gi = 0; gi < NB; gi++) begin : g_lane
         assign rd_merged[gi*BYTE_W +: BYTE_W] = byp_mask_reg[gi]
            ? byp_data_reg[gi*BYTE_W +: BYTE_W]
            : mem_rdata[gi*BYTE_W +: BYTE_W];
      end

      if (OUT_REG != 0) begin : g_out_reg
         logic [DATA_WIDTH-1:0] dout_reg;
         logic                  rd_v2_reg;
         always_ff @(posedge clka) begin
            if (rsta) begin
               dout_reg  <= '0;
               rd_v2_reg <= 1'b0;
            end else begin
               rd_v2_reg <= rd_v1_reg;
               if (rd_v1_reg) begin
                  dout_reg <= rd_merged;
               end
            end
         end
         assign doutb       = dout_reg;
         assign doutb_valid = rd_v2_reg;
      end else begin : g_no_out_reg
         // The array register cannot be reset, so mask it to zero until the
         // first read after reset has refreshed it.
         logic rd_seen_reg;
         always_ff @(posedge clka) begin
            if (rsta) begin
               rd_seen_reg <= 1'b0;
            end else if (rd_en) begin
               rd_seen_reg <= 1'b1;
            end
         end
         assign doutb       = rd_seen_reg ? rd_merged : '0;
         assign doutb_valid = rd_v1_reg;
      end
   endgenerate

endmodule

// File: tb/tb_bram_sdp_ctrl.sv
// Self-checking bench for bram_sdp_ctrl.
// dut0 (OUT_REG=0, BYPASS=1) and dut1 (OUT_REG=1, BYPASS=0) share one set of
// port stimulus; dut2 (ADDR_WIDTH=4, CLEAR_ON_RESET=1) has its own.
module tb_bram_sdp_ctrl;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   // group A stimulus (dut0, dut1)
   logic        rst_a;
   logic [7:0]  addra_a, addrb_a;
   logic [31:0] dina_a;
   logic [3:0]  wea_a;
   logic        reb_a;
   logic [31:0] doutb0, doutb1;
   logic        valid0, valid1, busy0, busy1;

   // dut2 stimulus
   logic        rst_c;
   logic [3:0]  addra_c, addrb_c;
   logic [31:0] dina_c;
   logic [3:0]  wea_c;
   logic        reb_c;
   logic [31:0] doutb2;
   logic        valid2, busy2;

   bram_sdp_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .OUT_REG(0), .BYPASS(1),
                   .CLEAR_ON_RESET(0), .INIT_FILE("")) dut0 (
      .clka(clk), .rsta(rst_a), .addra(addra_a), .dina(dina_a), .wea(wea_a),
      .addrb(addrb_a), .reb(reb_a), .doutb(doutb0), .doutb_valid(valid0),
      .init_busy(busy0));

   bram_sdp_ctrl #(.ADDR_WIDTH(8), .DATA_WIDTH(32), .OUT_REG(1), .BYPASS(0),
                   .CLEAR_ON_RESET(0), .INIT_FILE("")) dut1 (
      .clka(clk), .rsta(rst_a), .addra(addra_a), .dina(dina_a), .wea(wea_a),
      .addrb(addrb_a), .reb(reb_a), .doutb(doutb1), .doutb_valid(valid1),
      .init_busy(busy1));

   bram_sdp_ctrl #(.ADDR_WIDTH(4), .DATA_WIDTH(32), .OUT_REG(0), .BYPASS(1),
                   .CLEAR_ON_RESET(1), .INIT_FILE("")) dut2 (
      .clka(clk), .rsta(rst_c), .addra(addra_c), .dina(dina_c), .wea(wea_c),
      .addrb(addrb_c), .reb(reb_c), .doutb(doutb2), .doutb_valid(valid2),
      .init_busy(busy2));

   int n_cmp = 0;
   int n_bad = 0;
   bit chk_en = 1'b0;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %08h want %08h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // ---------------- behavioural model ----------------
   typedef struct {
      int          due;
      logic [31:0] d;
   } rd_t;

   rd_t         q0[$], q1[$], q2[$];
   logic [31:0] mem_a [256];
   logic [31:0] mem_c [16];
   logic        e0_v, e1_v, e2_v, e2_busy;
   logic [31:0] e0_d, e1_d, e2_d;
   int          cyc = 0;
   int          clr_left = 0;

   function automatic logic [31:0] merge(input logic [31:0] old_w,
                                         input logic [31:0] new_w,
                                         input logic [3:0]  we);
      logic [31:0] r;
      r = old_w;
      for (int i = 0; i < 4; i++) if (we[i]) r[i*8 +: 8] = new_w[i*8 +: 8];
      return r;
   endfunction

   initial forever begin
      rd_t t;
      logic [31:0] old_w;
      @(posedge clk);
      cyc++;
      // group A: a request sampled at edge k is due at edge k+OUT_REG
      if (rst_a) begin
         q0.delete(); q1.delete();
         e0_d = '0; e1_d = '0;
      end else begin
         if (reb_a) begin
            old_w = mem_a[addrb_a];
            t.due = cyc;
            t.d   = merge(old_w, dina_a, (addra_a == addrb_a) ? wea_a : 4'h0);
            q0.push_back(t);
            t.due = cyc + 1;
            t.d   = old_w;
            q1.push_back(t);
         end
         mem_a[addra_a] = merge(mem_a[addra_a], dina_a, wea_a);
      end
      e0_v = 1'b0;
      if (q0.size() > 0 && q0[0].due == cyc) begin
         e0_v = 1'b1; e0_d = q0[0].d; void'(q0.pop_front());
      end
      e1_v = 1'b0;
      if (q1.size() > 0 && q1[0].due == cyc) begin
         e1_v = 1'b1; e1_d = q1[0].d; void'(q1.pop_front());
      end
      // dut2: 16 dead cycles after every reset, then an all-zero array
      if (rst_c) begin
         q2.delete();
         e2_d = '0;
         clr_left = 16;
      end else if (clr_left > 0) begin
         clr_left--;
         if (clr_left == 0) for (int i = 0; i < 16; i++) mem_c[i] = '0;
      end else begin
         if (reb_c) begin
            t.due = cyc;
            t.d   = merge(mem_c[addrb_c], dina_c, (addra_c == addrb_c) ? wea_c : 4'h0);
            q2.push_back(t);
         end
         mem_c[addra_c] = merge(mem_c[addra_c], dina_c, wea_c);
      end
      e2_busy = (clr_left > 0);
      e2_v = 1'b0;
      if (q2.size() > 0 && q2[0].due == cyc) begin
         e2_v = 1'b1; e2_d = q2[0].d; void'(q2.pop_front());
      end
   end

   // ---------------- per-cycle compare ----------------
   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("m_valid0", {31'b0, valid0}, {31'b0, e0_v});
         check("m_dout0",  doutb0, e0_d);
         check("m_busy0",  {31'b0, busy0}, 32'd0);
         check("m_valid1", {31'b0, valid1}, {31'b0, e1_v});
         check("m_dout1",  doutb1, e1_d);
         check("m_busy1",  {31'b0, busy1}, 32'd0);
         check("m_valid2", {31'b0, valid2}, {31'b0, e2_v});
         check("m_dout2",  doutb2, e2_d);
         check("m_busy2",  {31'b0, busy2}, {31'b0, e2_busy});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
      $fatal(1);
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic a_wr(input logic [7:0] a, input logic [31:0] d, input logic [3:0] we);
      $display("A wr addr=%02h data=%08h we=%h", a, d, we);
      addra_a = a; dina_a = d; wea_a = we; reb_a = 1'b0;
      step();
      wea_a = 4'h0;
   endtask

   task automatic a_rd(input logic [7:0] a);
      $display("A rd addr=%02h", a);
      addrb_a = a; reb_a = 1'b1;
      step();
      reb_a = 1'b0;
   endtask

   task automatic c_wr(input logic [3:0] a, input logic [31:0] d);
      $display("C wr addr=%h data=%08h", a, d);
      addra_c = a; dina_c = d; wea_c = 4'hF;
      step();
      wea_c = 4'h0;
   endtask

   task automatic c_rd(input logic [3:0] a);
      $display("C rd addr=%h", a);
      addrb_c = a; reb_c = 1'b1;
      step();
      reb_c = 1'b0;
   endtask

   // Counts cycles from reset release until init_busy drops (bounded).
   task automatic c_count_busy(output int n);
      n = 0;
      while (busy2 && n < 40) begin
         addra_c = n[3:0]; dina_c = 32'hFFFF_FFFF; wea_c = 4'hF;
         addrb_c = n[3:0]; reb_c = 1'b1;
         step();
         n++;
      end
      wea_c = 4'h0; reb_c = 1'b0;
   endtask

   initial begin
      int n;
      rst_a = 1'b1; addra_a = '0; addrb_a = '0; dina_a = '0; wea_a = '0; reb_a = 1'b0;
      rst_c = 1'b1; addra_c = '0; addrb_c = '0; dina_c = '0; wea_c = '0; reb_c = 1'b0;
      step(); step();
      chk_en = 1'b1;
      check("rst_dout0",  doutb0, 32'd0);
      check("rst_valid1", {31'b0, valid1}, 32'd0);
      check("rst_busy2",  {31'b0, busy2}, 32'd1);
      rst_a = 1'b0; rst_c = 1'b0;

      // T1 basic write then read
      a_wr(8'h10, 32'hDEADBEEF, 4'hF);
      a_rd(8'h10);
      check("t1_valid0", {31'b0, valid0}, 32'd1);
      check("t1_dout0",  doutb0, 32'hDEADBEEF);
      check("t1_valid1_early", {31'b0, valid1}, 32'd0);
      step();
      check("t1_valid1", {31'b0, valid1}, 32'd1);
      check("t1_dout1",  doutb1, 32'hDEADBEEF);
      check("t1_hold0",  doutb0, 32'hDEADBEEF);

      // T2 byte lanes
      a_wr(8'h20, 32'h11223344, 4'hF);
      a_wr(8'h20, 32'hAABBCCDD, 4'b0101);
      a_rd(8'h20);
      check("t2_dout0", doutb0, 32'h11BB33DD);

      // T3 same-cycle collision
      a_wr(8'h30, 32'h0, 4'hF);
      $display("A wr+rd addr=30 data=CAFEF00D we=3");
      addra_a = 8'h30; dina_a = 32'hCAFEF00D; wea_a = 4'b0011;
      addrb_a = 8'h30; reb_a = 1'b1;
      step();
      wea_a = 4'h0; reb_a = 1'b0;
      check("t3_bypass", doutb0, 32'h0000F00D);
      step();
      check("t3_oldword", doutb1, 32'h00000000);
      a_rd(8'h30);
      check("t3_new0", doutb0, 32'h0000F00D);
      step();
      check("t3_new1", doutb1, 32'h0000F00D);

      // T4 back-to-back reads through the output register
      for (int i = 0; i < 3; i++) a_wr(8'(i), 32'h100 + i, 4'hF);
      $display("A rd burst addr=00,01,02");
      reb_a = 1'b1; addrb_a = 8'h00; step();
      check("t4_v_slot0", {31'b0, valid1}, 32'd0);
      addrb_a = 8'h01; step();
      check("t4_d0", doutb1, 32'h100);
      check("t4_v0", {31'b0, valid1}, 32'd1);
      addrb_a = 8'h02; step();
      check("t4_d1", doutb1, 32'h101);
      reb_a = 1'b0; step();
      check("t4_d2", doutb1, 32'h102);
      check("t4_v2", {31'b0, valid1}, 32'd1);
      step();
      check("t4_v_end", {31'b0, valid1}, 32'd0);

      // T6 (ports): reset with a read in flight in the output pipe
      $display("A rd addr=10 then reset");
      addrb_a = 8'h10; reb_a = 1'b1; step();
      reb_a = 1'b0; rst_a = 1'b1; step();
      check("t6_flush_v1", {31'b0, valid1}, 32'd0);
      check("t6_flush_d1", doutb1, 32'd0);
      rst_a = 1'b0; step();
      check("t6_after_v1", {31'b0, valid1}, 32'd0);

      // T5 zero fill after reset
      n = 0;
      while (busy2 && n < 40) begin step(); n++; end
      check("t5_first_ready", {31'b0, busy2}, 32'd0);
      for (int i = 0; i < 16; i++) c_wr(4'(i), 32'hA5A5_0000 + i);
      c_rd(4'd9);
      check("t5_preload", doutb2, 32'hA5A5_0009);
      $display("C reset pulse");
      rst_c = 1'b1; step(); rst_c = 1'b0;
      check("t5_busy_rst", {31'b0, busy2}, 32'd1);
      c_count_busy(n);
      check("t5_busy_len", n, 32'd16);
      for (int i = 0; i < 16; i++) begin
         c_rd(4'(i));
         check("t5_zero", doutb2, 32'd0);
         check("t5_zero_v", {31'b0, valid2}, 32'd1);
      end

      // T6 (clear): reset when the fill has reached address 7
      c_wr(4'd7, 32'h7777_7777);
      c_wr(4'd8, 32'h8888_8888);
      $display("C reset pulse, re-reset at clear address 7");
      rst_c = 1'b1; step(); rst_c = 1'b0;
      for (int i = 0; i < 7; i++) step();
      rst_c = 1'b1; addrb_c = 4'd3; reb_c = 1'b1; step();
      rst_c = 1'b0; reb_c = 1'b0;
      check("t6_busy_restart", {31'b0, busy2}, 32'd1);
      c_count_busy(n);
      check("t6_busy_len", n, 32'd16);
      c_rd(4'd8);
      check("t6_zero8", doutb2, 32'd0);
      c_wr(4'd5, 32'h5A5A_1234);
      c_rd(4'd5);
      check("t6_wr_after", doutb2, 32'h5A5A_1234);
      step(); step();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
